// File: rtl/pll_reset_pkg.sv
// Shared types and helpers for the PLL bring-up reset sequencer.
// The FSM encoding is fixed because the state is exported for debug.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    // Width of a counter that must reach the larger of the two intervals
    function automatic int cnt_width(input int lock_cycles, input int hold_cycles);
        int max_v;
        if (lock_cycles > hold_cycles) begin
            max_v = lock_cycles;
        end else begin
            max_v = hold_cycles;
        end
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous level inputs.
// Both stages clear to 0 under the synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= 1'b0;
            q_r    <= 1'b0;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Bring-up sequencer: waits for a stable PLL lock, holds the system reset for a
// fixed interval, and re-enters reset on lock loss or a software request.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int LOSS_COUNT_WIDTH   = 8
) (
    input  logic                        clk_1x,
    input  logic                        reset,
    input  logic                        locked,
    input  logic                        soft_reset,
    output logic                        reset_out,
    output logic                        ready,
    output logic [1:0]                  state,
    output logic [LOSS_COUNT_WIDTH-1:0] lock_loss_count
);

    localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [LOSS_COUNT_WIDTH-1:0] LOSS_ZERO = {LOSS_COUNT_WIDTH{1'b0}};
    localparam logic [LOSS_COUNT_WIDTH-1:0] LOSS_ONE  = LOSS_COUNT_WIDTH'(1);
    localparam logic [LOSS_COUNT_WIDTH-1:0] LOSS_MAX  = {LOSS_COUNT_WIDTH{1'b1}};

    logic                        locked_s;
    pll_state_e                  state_r;
    pll_state_e                  next_state_s;
    logic [CNT_W-1:0]            cnt_r;
    logic [CNT_W-1:0]            cnt_next_s;
    logic                        loss_inc_s;
    logic [LOSS_COUNT_WIDTH-1:0] loss_cnt_r;
    logic [LOSS_COUNT_WIDTH-1:0] loss_next_s;
    logic                        reset_out_r;
    logic                        ready_r;

    sync_2ff u_lock_sync (
        .clk   (clk_1x),
        .reset (reset),
        .d     (locked),
        .q     (locked_s)
    );

    // Next-state and interval counter; lock loss takes priority over soft_reset
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        loss_inc_s   = 1'b0;
        case (state_r)
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state_s = SETTLE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    next_state_s = WAIT_LOCK;
                end
            end
            SETTLE: begin
                if (!locked_s) begin
                    next_state_s = WAIT_LOCK;
                end else if (cnt_r == SETTLE_LAST) begin
                    next_state_s = HOLD;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    next_state_s = WAIT_LOCK;
                end else if (cnt_r == HOLD_LAST) begin
                    next_state_s = RUN;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    next_state_s = WAIT_LOCK;
                    loss_inc_s   = 1'b1;
                end else if (soft_reset) begin
                    next_state_s = HOLD;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = WAIT_LOCK;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Saturating lock-loss counter increment
    always_comb begin
        loss_next_s = loss_cnt_r;
        if (loss_inc_s && (loss_cnt_r != LOSS_MAX)) begin
            loss_next_s = loss_cnt_r + LOSS_ONE;
        end else begin
            loss_next_s = loss_cnt_r;
        end
    end

    // State, counters and outputs; outputs follow next-state so they move with the state
    always_ff @(posedge clk_1x) begin
        if (reset) begin
            state_r     <= WAIT_LOCK;
            cnt_r       <= CNT_ZERO;
            loss_cnt_r  <= LOSS_ZERO;
            reset_out_r <= 1'b1;
            ready_r     <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            cnt_r       <= cnt_next_s;
            loss_cnt_r  <= loss_next_s;
            reset_out_r <= (next_state_s != RUN);
            ready_r     <= (next_state_s == RUN);
        end
    end

    assign reset_out       = reset_out_r;
    assign ready           = ready_r;
    assign state           = state_r;
    assign lock_loss_count = loss_cnt_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: a fixed bring-up table, directed
// corner sequences, and random stimulus against a run-length reference model.
module tb_pll_reset_sequencer;

    localparam int L = 4;
    localparam int H = 3;
    localparam int W = 2;

    logic         clk_1x = 1'b0;
    logic         reset = 1'b1;
    logic         locked = 1'b0;
    logic         soft_reset = 1'b0;
    logic         reset_out;
    logic         ready;
    logic [1:0]   state;
    logic [W-1:0] lock_loss_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: locked samples in flight, length of the current lock run
    bit m_hist[$];
    int m_run  = 0;
    int m_loss = 0;

    always #5 clk_1x = ~clk_1x;

    pll_reset_sequencer #(
        .LOCK_STABLE_CYCLES (L),
        .RESET_HOLD_CYCLES  (H),
        .LOSS_COUNT_WIDTH   (W)
    ) dut (
        .clk_1x          (clk_1x),
        .reset           (reset),
        .locked          (locked),
        .soft_reset      (soft_reset),
        .reset_out       (reset_out),
        .ready           (ready),
        .state           (state),
        .lock_loss_count (lock_loss_count)
    );

    typedef struct {
        bit r;
        bit lk;
        bit sr;
        int st;
        bit ro;
    } vec_t;

    vec_t tbl[15];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // State implied by how many consecutive edges have seen a synchronised lock
    function automatic int model_state();
        if (m_run == 0) return 0;
        else if (m_run <= L) return 1;
        else if (m_run <= L + H) return 2;
        else return 3;
    endfunction

    task automatic model_edge(input bit r, input bit lk, input bit sr);
        bit ls;
        bit in_run;
        if (r) begin
            m_hist = {1'b0, 1'b0};
            m_run  = 0;
            m_loss = 0;
        end else begin
            ls = m_hist.pop_front();
            m_hist.push_back(lk);
            in_run = (m_run > L + H);
            if (ls) begin
                if (in_run && sr) m_run = L + 1;
                else if (m_run < 1000) m_run++;
            end else begin
                if (in_run && m_loss < (1 << W) - 1) m_loss++;
                m_run = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit lk, input bit sr);
        int es;
        reset      = r;
        locked     = lk;
        soft_reset = sr;
        @(posedge clk_1x);
        model_edge(r, lk, sr);
        #1;
        es = model_state();
        check("state", int'(state), es);
        check("reset_out", int'(reset_out), int'(es != 3));
        check("ready", int'(ready), int'(es == 3));
        check("lock_loss_count", int'(lock_loss_count), m_loss);
    endtask

    initial begin
        int hi;
        int fall_at;
        int prev;
        int st_trace[10] = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 3};
        bit lk_r;

        m_hist = {1'b0, 1'b0};

        for (int i = 0; i < 5; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 0, 1'b1};
        for (int i = 0; i < 10; i++) tbl[5 + i] = '{1'b0, 1'b1, 1'b0, st_trace[i], (i < 9)};

        // Bring-up from reset: locked rises at e0, reset_out falls at e9
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].lk, tbl[i].sr);
            check($sformatf("tbl_state[%0d]", i), int'(state), tbl[i].st);
            check($sformatf("tbl_reset_out[%0d]", i), int'(reset_out), int'(tbl[i].ro));
            check($sformatf("tbl_ready[%0d]", i), int'(ready), int'(!tbl[i].ro));
        end
        check("tbl_loss", int'(lock_loss_count), 0);

        // Soft reset in RUN: reset_out high for exactly H cycles
        hi = 0;
        step(1'b0, 1'b1, 1'b1);
        if (reset_out) hi++;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (reset_out) hi++;
        end
        check("soft_hold_len", hi, H);
        check("soft_loss_unchanged", int'(lock_loss_count), 0);

        // Lock loss in RUN: seen two edges after the sampling edge
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("loss_not_yet", int'(state), 3);
        step(1'b0, 1'b0, 1'b0);
        check("loss_state", int'(state), 0);
        check("loss_reset_out", int'(reset_out), 1);
        check("loss_count1", int'(lock_loss_count), 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 8) check("relock_e8", int'(reset_out), 1);
            if (i == 9) check("relock_e9", int'(reset_out), 0);
        end

        // Settle abort: 3 high, 1 low, then high; no loss counted, full restart
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
        check("abort_pre_count", int'(lock_loss_count), 2);
        fall_at = -1;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, (i != 3), 1'b0);
            if (!reset_out && fall_at < 0) fall_at = i;
        end
        check("abort_fall_edge", fall_at, 4 + 9);
        check("abort_count", int'(lock_loss_count), 2);

        // Lock loss and soft_reset on the same edge: loss wins
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("prio_state", int'(state), 0);
        check("prio_count", int'(lock_loss_count), 3);

        // Saturation at 2^W-1 after further losses
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        end
        check("sat_count", int'(lock_loss_count), 3);

        // Reset while in RUN clears everything on the next edge
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        check("pre_reset_run", int'(state), 3);
        step(1'b1, 1'b1, 1'b0);
        check("rst_state", int'(state), 0);
        check("rst_reset_out", int'(reset_out), 1);
        check("rst_count", int'(lock_loss_count), 0);

        // Random stimulus: long lock runs, occasional drops, soft and hard resets
        lk_r = 1'b1;
        prev = 0;
        for (int i = 0; i < 3000; i++) begin
            if (lk_r) lk_r = ($urandom_range(0, 39) != 0);
            else      lk_r = ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 299) == 0), lk_r, ($urandom_range(0, 19) == 0));
            prev = prev + int'(state == 2'd3);
        end
        check("random_reached_run", int'(prev > 0), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
